// File: rtl/sum_mem_scheduler_if.sv
// rtl/sum_mem_scheduler_if.sv - request, response and memory-port bundle for sum_mem_scheduler
interface sum_mem_scheduler_if #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [AWIDTH-1:0] req0_base;
    logic [AWIDTH:0]   req0_size;
    logic [AWIDTH-1:0] req1_base;
    logic [AWIDTH:0]   req1_size;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [DWIDTH-1:0] resp_sum;
    logic              mem_en;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_rdata;

    // Board-level control plus the memory itself
    modport master (
        output req_valid, req0_base, req0_size, req1_base, req1_size,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_id, resp_sum, mem_en, mem_addr
    );

    modport slave (
        input  req_valid, req0_base, req0_size, req1_base, req1_size,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_id, resp_sum, mem_en, mem_addr
    );
endinterface

// File: rtl/sum_mem_scheduler.sv
// rtl/sum_mem_scheduler.sv - round-robin two-requester summing scheduler over one sync-read memory port
// Optional resp_cycles_o latency report is built when SUM_SCHED_CYCLES_EN is defined.
module sum_mem_scheduler #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    sum_mem_scheduler_if.slave    bus,
`ifdef SUM_SCHED_CYCLES_EN
    output logic [31:0]           resp_cycles_o,
`endif
    output logic                  busy_o
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, RESP} state_t;

    localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);

    state_t            state_q;
    logic [AWIDTH-1:0] addr_q;
    logic [AWIDTH:0]   rem_q;
    logic              mem_en_q;
    logic              rvalid_q;
    logic [DWIDTH-1:0] acc_q;
    logic [DWIDTH-1:0] resp_sum_q;
    logic              resp_valid_q;
    logic              resp_id_q;
    logic              last_q;
    logic              holdoff_q;

    logic              grant_id;
    logic [1:0]        grant;
    logic              accept;
    logic [AWIDTH-1:0] sel_base;
    logic [AWIDTH:0]   sel_size;
    logic [AWIDTH:0]   size_c;

    // Contended grant goes to whoever was not served last; holdoff blocks the first IDLE cycle after a response
    always_comb begin
        grant_id = 1'b0;
        case (bus.req_valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_q;
            default: grant_id = 1'b0;
        endcase
        grant = 2'b00;
        if (reset_n_i && state_q == IDLE && !holdoff_q && bus.req_valid != 2'b00) begin
            grant = grant_id ? 2'b10 : 2'b01;
        end
    end

    assign accept   = |grant;
    assign sel_base = grant_id ? bus.req1_base : bus.req0_base;
    assign sel_size = grant_id ? bus.req1_size : bus.req0_size;
    assign size_c   = (sel_size > DEPTH_W) ? DEPTH_W : sel_size;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            mem_en_q     <= 1'b0;
            rvalid_q     <= 1'b0;
            acc_q        <= '0;
            resp_sum_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            last_q       <= 1'b1;
            holdoff_q    <= 1'b0;
        end else begin
            rvalid_q  <= mem_en_q;
            holdoff_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        last_q    <= grant_id;
                        resp_id_q <= grant_id;
                        acc_q     <= '0;
                        if (size_c == '0) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_sum_q   <= '0;
                        end else begin
                            state_q  <= READ;
                            mem_en_q <= 1'b1;
                            addr_q   <= sel_base;
                            rem_q    <= size_c - 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rvalid_q) begin
                        acc_q <= acc_q + bus.mem_rdata;
                    end
                    if (rem_q == '0) begin
                        state_q  <= DRAIN;
                        mem_en_q <= 1'b0;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                        rem_q  <= rem_q - 1'b1;
                    end
                end
                DRAIN: begin
                    // Data for the last issued address lands here
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_sum_q   <= acc_q + bus.mem_rdata;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        holdoff_q    <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SUM_SCHED_CYCLES_EN
    logic [31:0] cyc_q;
    logic [31:0] resp_cycles_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cyc_q         <= '0;
            resp_cycles_q <= '0;
        end else begin
            if (state_q == IDLE && accept) begin
                cyc_q <= 32'd1;
                if (size_c == '0) begin
                    resp_cycles_q <= 32'd1;
                end
            end else if (state_q == READ && cyc_q != '1) begin
                cyc_q <= cyc_q + 32'd1;
            end
            if (state_q == DRAIN) begin
                resp_cycles_q <= (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;
            end
        end
    end

    assign resp_cycles_o = resp_cycles_q;
`endif

    assign bus.req_ready  = grant;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_sum   = resp_sum_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_addr   = addr_q;
    assign busy_o         = (state_q != IDLE);
endmodule

// File: tb/tb_sum_mem_scheduler.sv
// tb/tb_sum_mem_scheduler.sv - self-checking bench for sum_mem_scheduler
module tb_sum_mem_scheduler;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic reset_n;
    logic busy;
`ifdef SUM_SCHED_CYCLES_EN
    logic [31:0] resp_cycles;
`endif
    int n_checks = 0;
    int n_fail   = 0;
    bit last_srv;
    logic [DW-1:0] mem [DEPTH];

    sum_mem_scheduler_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    sum_mem_scheduler #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .bus           (bus),
`ifdef SUM_SCHED_CYCLES_EN
        .resp_cycles_o (resp_cycles),
`endif
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.mem_rdata <= '0;
        else if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_sum(input int base, input int size);
        logic [31:0] s;
        int n;
        s = '0;
        n = (size > DEPTH) ? DEPTH : size;
        for (int i = 0; i < n; i++) s += mem[(base + i) % DEPTH];
        return s;
    endfunction

    function automatic int model_lat(input int size);
        int n;
        n = (size > DEPTH) ? DEPTH : size;
        return (n == 0) ? 1 : n + 2;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit id, input int base, input int size);
        if (id) begin
            bus.req1_base = AW'(base);
            bus.req1_size = (AW+1)'(size);
        end else begin
            bus.req0_base = AW'(base);
            bus.req0_size = (AW+1)'(size);
        end
        bus.req_valid[id] = 1'b1;
    endtask

    task automatic wait_grant(input bit id, output int waited);
        logic [1:0] exp;
        exp = id ? 2'b10 : 2'b01;
        waited = 0;
        @(negedge clk); #1;
        while (bus.req_ready == 2'b00 && waited < 50) begin
            @(negedge clk); #1;
            waited++;
        end
        check("req_ready_grant", bus.req_ready, exp);
    endtask

    task automatic collect(input bit id, input int base, input int size,
                           input logic [31:0] exp_sum, input int exp_lat, input int stall);
        int n, issued, lat, cyc, bad_act, bad_exp;
        bit bad;
        n = (size > DEPTH) ? DEPTH : size;
        issued = 0; lat = 0; cyc = 0; bad = 0; bad_act = 0; bad_exp = 0;
        while (lat == 0 && cyc < 1200) begin
            @(negedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                bus.req_valid[id] = 1'b0;
                if (id) begin
                    bus.req1_base = AW'($urandom);
                    bus.req1_size = (AW+1)'($urandom);
                end else begin
                    bus.req0_base = AW'($urandom);
                    bus.req0_size = (AW+1)'($urandom);
                end
            end
            if (bus.mem_en) begin
                if (!bad && (int'(bus.mem_addr) != (base + issued) % DEPTH || cyc != issued + 1)) begin
                    bad = 1'b1;
                    bad_act = int'(bus.mem_addr);
                    bad_exp = (base + issued) % DEPTH;
                end
                issued++;
            end
            if (bus.resp_valid) lat = cyc;
        end
        check(bad ? "mem_addr_first_bad" : "mem_addr_seq", bad ? bad_act : 0, bad ? bad_exp : 0);
        check("mem_issue_count", issued, n);
        check("resp_latency", lat, exp_lat);
        check("resp_sum", bus.resp_sum, exp_sum);
        check("resp_id", bus.resp_id, id);
        check("busy_in_resp", busy, 1);
`ifdef SUM_SCHED_CYCLES_EN
        check("resp_cycles", resp_cycles, exp_lat);
`endif
        for (int s = 0; s < stall; s++) begin
            @(negedge clk); #1;
            check("stall_resp_valid", bus.resp_valid, 1);
            check("stall_resp_sum", bus.resp_sum, exp_sum);
            check("stall_req_ready", bus.req_ready, 0);
        end
        @(negedge clk); #1;
        bus.resp_ready = 1'b1;
        sync();
        bus.resp_ready = 1'b0;
        check("resp_valid_after_ack", bus.resp_valid, 0);
    endtask

    typedef struct {
        bit          id;
        int          base;
        int          size;
        int          stall;
        logic [31:0] exp_sum;
        int          exp_lat;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int w;
        tbl[0] = '{id: 1'b0, base: 0,    size: 1024, stall: 0, exp_sum: 32'd523776, exp_lat: 1026};
        tbl[1] = '{id: 1'b1, base: 1020, size: 8,    stall: 0, exp_sum: 32'd4092,   exp_lat: 10};
        tbl[2] = '{id: 1'b0, base: 0,    size: 0,    stall: 2, exp_sum: 32'd0,      exp_lat: 1};
        tbl[3] = '{id: 1'b1, base: 5,    size: 2047, stall: 0, exp_sum: 32'd523776, exp_lat: 1026};
        tbl[4] = '{id: 1'b1, base: 1023, size: 1,    stall: 1, exp_sum: 32'd1023,   exp_lat: 3};
        tbl[5] = '{id: 1'b0, base: 10,   size: 3,    stall: 3, exp_sum: 32'd33,     exp_lat: 5};

        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
        reset_n        = 1'b0;
        bus.req_valid  = 2'b00;
        bus.resp_ready = 1'b0;
        issue(0, 0, 4);
        issue(1, 0, 4);
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_resp_sum", bus.resp_sum, 0);
        bus.req_valid = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        sync();

        // Round robin from reset: requester 0 first, then 1, then 0 again
        issue(0, 0, 4);
        issue(1, 0, 4);
        wait_grant(0, w);
        check("rr_first_wait", w, 0);
        collect(0, 0, 4, 32'd6, 6, 0);
        wait_grant(1, w);
        check("rr_second_wait", w, 1);
        collect(1, 0, 4, 32'd6, 6, 0);
        issue(0, 0, 4);
        wait_grant(0, w);
        collect(0, 0, 4, 32'd6, 6, 0);
        bus.req_valid = 2'b00;

        for (int i = 0; i < 6; i++) begin
            issue(tbl[i].id, tbl[i].base, tbl[i].size);
            wait_grant(tbl[i].id, w);
            collect(tbl[i].id, tbl[i].base, tbl[i].size, tbl[i].exp_sum, tbl[i].exp_lat, tbl[i].stall);
        end

        // Long response stall with a competing request pending
        issue(1, 10, 3);
        issue(0, 100, 2);
        wait_grant(1, w);
        collect(1, 10, 3, 32'd33, 5, 20);
        wait_grant(0, w);
        check("accept_after_resp_wait", w, 1);
        collect(0, 100, 2, 32'd201, 4, 0);

        // Reset in the middle of a long read
        issue(0, 0, 1024);
        wait_grant(0, w);
        repeat (100) @(negedge clk);
        #1;
        check("midread_mem_en", bus.mem_en, 1);
        check("midread_addr", bus.mem_addr, 99);
        reset_n = 1'b0;
        bus.req_valid = 2'b00;
        #1;
        check("midrst_mem_en", bus.mem_en, 0);
        check("midrst_mem_addr", bus.mem_addr, 0);
        check("midrst_busy", busy, 0);
        check("midrst_resp_valid", bus.resp_valid, 0);
        check("midrst_resp_sum", bus.resp_sum, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        sync();
        check("postrst_resp_valid", bus.resp_valid, 0);
        issue(0, 0, 2);
        wait_grant(0, w);
        collect(0, 0, 2, 32'd1, 4, 0);
        last_srv = 1'b0;

        // Randomized traffic against the reference model with random memory contents
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        for (int it = 0; it < 40; it++) begin
            int vm, b0, b1, s0, s1, r;
            bit win;
            vm = $urandom_range(1, 3);
            b0 = $urandom_range(0, DEPTH - 1);
            b1 = $urandom_range(0, DEPTH - 1);
            r  = $urandom_range(0, 7);
            s0 = (r == 0) ? 0 : (r == 1) ? $urandom_range(1000, 2047) : $urandom_range(1, 40);
            r  = $urandom_range(0, 7);
            s1 = (r == 0) ? 0 : (r == 1) ? $urandom_range(1000, 2047) : $urandom_range(1, 40);
            win = (vm == 3) ? !last_srv : (vm == 2);
            if (vm[0]) issue(0, b0, s0);
            if (vm[1]) issue(1, b1, s1);
            wait_grant(win, w);
            check("rand_accept_wait", w, 1);
            if (win) collect(1, b1, s1, model_sum(b1, s1), model_lat(s1), $urandom_range(0, 3));
            else     collect(0, b0, s0, model_sum(b0, s0), model_lat(s0), $urandom_range(0, 3));
            bus.req_valid = 2'b00;
            last_srv = win;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
